// File: rtl/channel_step_recorder_if.sv
// Control and trigger bundle between the pad-scan front end / trigger logic
// and one channel_step_recorder instance.
interface channel_step_recorder_if;
  logic       playEn;
  logic       recEn;
  logic       clear;
  logic [1:0] data;
  logic [1:0] seqOut;
  logic [5:0] step;
  logic       tick;

  // Front end / controller side: drives controls and pad levels.
  modport master (
    output playEn, recEn, clear, data,
    input  seqOut, step, tick
  );

  // Recorder side.
  modport slave (
    input  playEn, recEn, clear, data,
    output seqOut, step, tick
  );
endinterface

// File: rtl/channel_step_recorder.sv
// Live step recorder for a channel pair: quantizes pad hits to the nearest
// step, overdubs them into a circular step memory and plays that memory back
// as one-cycle trigger pulses on every step tick.
module channel_step_recorder #(
  parameter int STEPS    = 40,
  parameter int STEP_DIV = 11025
) (
  input  logic                        clock,
  input  logic                        resetn,
  channel_step_recorder_if.slave      bus
);

  localparam int CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PW   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int HALF = STEP_DIV / 2;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(HALF);
  localparam logic [PW-1:0] PTR_LAST   = PW'(STEPS - 1);

  logic [1:0]    r_mem [0:STEPS-1];
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_cur;
  logic [1:0]    r_early;
  logic [1:0]    r_prev;
  logic [1:0]    r_seq;
  logic          r_tick;

  logic [1:0]    w_rise;
  logic          w_rec;
  logic          w_tick;
  logic          w_late;
  logic [PW-1:0] w_ptr_next;
  logic [1:0]    w_hit;

  // A pad that stays pressed only counts on its first cycle.
  assign w_rise     = bus.data & ~r_prev;
  assign w_rec      = bus.playEn & bus.recEn;
  assign w_tick     = bus.playEn & (r_cnt == CW'(0));
  // Second half of a step (counter still high) belongs to the step just played.
  assign w_late     = (r_cnt >= CNT_HALF);
  assign w_ptr_next = (r_ptr == PTR_LAST) ? PW'(0) : (r_ptr + PW'(1));
  // Hits committed into the step being ticked: pending early bits plus any
  // rise landing on the tick cycle itself.
  assign w_hit      = w_rec ? (r_early | w_rise) : 2'b00;

  assign bus.seqOut = r_seq;
  assign bus.tick   = r_tick;
  assign bus.step   = 6'(r_cur);

  // Step engine, hit quantization and pattern memory.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STEPS; i++) begin
        r_mem[i] <= 2'b00;
      end
      r_cnt   <= CNT_RELOAD;
      r_ptr   <= PW'(0);
      r_cur   <= PTR_LAST;
      r_early <= 2'b00;
      r_prev  <= 2'b00;
      r_seq   <= 2'b00;
      r_tick  <= 1'b0;
    end else begin
      // Edge history tracks the pads even while frozen so that a held pad
      // does not fire on resume.
      r_prev <= bus.data;
      if (bus.clear) begin
        for (int i = 0; i < STEPS; i++) begin
          r_mem[i] <= 2'b00;
        end
        r_cnt   <= CNT_RELOAD;
        r_ptr   <= PW'(0);
        r_cur   <= PTR_LAST;
        r_early <= 2'b00;
        r_seq   <= 2'b00;
        r_tick  <= 1'b0;
      end else if (!bus.playEn) begin
        r_cnt   <= CNT_RELOAD;
        r_early <= 2'b00;
        r_seq   <= 2'b00;
        r_tick  <= 1'b0;
      end else if (w_tick) begin
        r_cnt        <= CNT_RELOAD;
        r_seq        <= r_mem[r_ptr] | w_hit;
        r_tick       <= 1'b1;
        r_mem[r_ptr] <= r_mem[r_ptr] | w_hit;
        r_early      <= 2'b00;
        r_cur        <= r_ptr;
        r_ptr        <= w_ptr_next;
      end else begin
        r_cnt  <= r_cnt - CW'(1);
        r_seq  <= 2'b00;
        r_tick <= 1'b0;
        if (w_rec && w_late) begin
          // Late hit: stored for the next pass, not sounded now.
          r_mem[r_cur] <= r_mem[r_cur] | w_rise;
        end else if (w_rec) begin
          r_early <= r_early | w_rise;
        end else begin
          r_early <= r_early;
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_step_recorder.sv
// Directed bench for channel_step_recorder with STEPS=4, STEP_DIV=8.
module tb_channel_step_recorder;

  logic clock;
  logic resetn;
  int   n_tests;
  int   n_fail;
  int   cyc_n;

  channel_step_recorder_if bus();

  channel_step_recorder #(.STEPS(4), .STEP_DIV(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock edge, then settle away from the edge.
  task automatic clk1();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  // Advance to the next tick (cyc_n multiple of 8); intermediate cycles must
  // be silent, the tick cycle must show the given step and pulse.
  task automatic to_tick(input string tag, input logic [5:0] es, input logic [1:0] eq);
    for (int k = 0; k < 8; k++) begin
      clk1();
      if ((cyc_n % 8) == 0) begin
        chk({tag, "_tick"}, {7'd0, bus.tick}, 8'd1);
        chk({tag, "_step"}, {2'd0, bus.step}, {2'd0, es});
        chk({tag, "_seq"},  {6'd0, bus.seqOut}, {6'd0, eq});
        break;
      end else begin
        chk({tag, "_quiet"}, {5'd0, bus.tick, bus.seqOut}, 8'd0);
      end
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    cyc_n      = 0;
    resetn     = 1'b1;
    bus.playEn = 1'b0;
    bus.recEn  = 1'b0;
    bus.clear  = 1'b0;
    bus.data   = 2'b00;

    // Reset state
    #2 resetn = 1'b0;
    #10;
    chk("rst_seq",  {6'd0, bus.seqOut}, 8'd0);
    chk("rst_tick", {7'd0, bus.tick}, 8'd0);
    chk("rst_step", {2'd0, bus.step}, 8'd3);
    @(posedge clock);
    #1 resetn = 1'b1;
    clk1();
    chk("idle_frozen", {5'd0, bus.tick, bus.seqOut}, 8'd0);

    // Idle playback: 40 cycles, steps 0,1,2,3,0, no pulses
    bus.playEn = 1'b1;
    cyc_n = 0;
    to_tick("idle0", 6'd0, 2'b00);
    to_tick("idle1", 6'd1, 2'b00);
    to_tick("idle2", 6'd2, 2'b00);
    to_tick("idle3", 6'd3, 2'b00);
    to_tick("idle4", 6'd0, 2'b00);

    // Late hit on ch0 at cnt=6 of cur=0
    bus.recEn = 1'b1;
    clk1();                 // cycle 42 (cnt=6) is next
    bus.data = 2'b01;
    clk1();
    bus.data = 2'b00;
    to_tick("late1", 6'd1, 2'b00);
    to_tick("late2", 6'd2, 2'b00);
    to_tick("late3", 6'd3, 2'b00);
    to_tick("late0", 6'd0, 2'b01);

    // Early hit on ch1 at cnt=2 of cur=0
    for (int k = 0; k < 5; k++) clk1();
    bus.data = 2'b10;
    clk1();
    bus.data = 2'b00;
    to_tick("early1", 6'd1, 2'b10);
    to_tick("early2", 6'd2, 2'b00);
    to_tick("early3", 6'd3, 2'b00);
    to_tick("early0", 6'd0, 2'b01);
    to_tick("early1b", 6'd1, 2'b10);

    // Held 11 from cnt=6 of cur=2 across three ticks
    to_tick("held_pre2", 6'd2, 2'b00);
    clk1();
    bus.data = 2'b11;
    to_tick("held3", 6'd3, 2'b00);
    to_tick("held0", 6'd0, 2'b01);
    to_tick("held1", 6'd1, 2'b10);
    bus.data = 2'b00;
    to_tick("held2", 6'd2, 2'b11);
    to_tick("held3b", 6'd3, 2'b00);

    // Clear in a tick cycle while data rises
    for (int k = 0; k < 7; k++) clk1();
    bus.clear = 1'b1;
    bus.data  = 2'b11;
    clk1();
    bus.clear = 1'b0;
    bus.data  = 2'b00;
    chk("clr_pulse", {5'd0, bus.tick, bus.seqOut}, 8'd0);
    chk("clr_step", {2'd0, bus.step}, 8'd3);
    to_tick("clr0", 6'd0, 2'b00);
    to_tick("clr1", 6'd1, 2'b00);
    to_tick("clr2", 6'd2, 2'b00);
    to_tick("clr3", 6'd3, 2'b00);
    to_tick("clr0b", 6'd0, 2'b00);

    // Freeze at cnt=3 of cur=1
    to_tick("frz_pre1", 6'd1, 2'b00);
    for (int k = 0; k < 4; k++) clk1();
    bus.playEn = 1'b0;
    for (int k = 0; k < 20; k++) begin
      clk1();
      chk("frz_quiet", {5'd0, bus.tick, bus.seqOut}, 8'd0);
      chk("frz_step", {2'd0, bus.step}, 8'd1);
    end

    // Resume with an early ch1 hit at cnt=2; tick after 8 cycles on step 2
    bus.playEn = 1'b1;
    cyc_n = 0;
    for (int k = 0; k < 5; k++) clk1();
    bus.data = 2'b10;
    clk1();
    bus.data = 2'b00;
    to_tick("resume2", 6'd2, 2'b10);

    // Asynchronous reset in the middle of the pulse
    #2 resetn = 1'b0;
    #1;
    chk("arst_seq",  {6'd0, bus.seqOut}, 8'd0);
    chk("arst_tick", {7'd0, bus.tick}, 8'd0);
    chk("arst_step", {2'd0, bus.step}, 8'd3);
    @(posedge clock);
    #1 resetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
